// File: rtl/handshake_constant_seq.sv
// Elastic constant/sequence source: every accepted control token yields REPEAT
// registered output beats carrying CONST_VALUE + k*STRIDE (k = 0..REPEAT-1).
module handshake_constant_seq #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CONST_VALUE = 32'h1EE65,
  parameter int unsigned STRIDE      = 0,
  parameter int unsigned REPEAT      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  state_dbg
);

  localparam int unsigned CNT_WIDTH = ($clog2(REPEAT) > 0) ? $clog2(REPEAT) : 1;
  localparam logic [DATA_WIDTH-1:0] CONST_V  = DATA_WIDTH'(CONST_VALUE);
  localparam logic [DATA_WIDTH-1:0] STRIDE_V = DATA_WIDTH'(STRIDE);
  localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(REPEAT - 1);

  // Handshakes: a token moves on a rising edge where valid && ready are both
  // high. outs/outs_valid never depend combinationally on ctrl_valid or
  // outs_ready, and outs is held stable while outs_valid && !outs_ready.

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                  state_q, state_next;
  logic [DATA_WIDTH-1:0]   outs_q, outs_next;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_next;
  logic                    last_beat;

  assign last_beat  = (cnt_q == '0);
  assign outs       = outs_q;
  assign outs_valid = (state_q == EMIT);
  assign state_dbg  = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      outs_q  <= CONST_V;
      cnt_q   <= '0;
    end else begin
      state_q <= state_next;
      outs_q  <= outs_next;
      cnt_q   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_q;
    outs_next  = outs_q;
    cnt_next   = cnt_q;
    ctrl_ready = 1'b0;
    case (state_q)
      IDLE: begin
        ctrl_ready = 1'b1;
        if (ctrl_valid) begin
          state_next = EMIT;
          outs_next  = CONST_V;
          cnt_next   = LAST_CNT;
        end
      end
      EMIT: begin
        // A new token can only be taken in the cycle the final beat leaves,
        // which is what lets bursts run back to back without a bubble.
        ctrl_ready = last_beat && outs_ready;
        if (outs_ready) begin
          if (!last_beat) begin
            outs_next = outs_q + STRIDE_V;
            cnt_next  = cnt_q - 1'b1;
          end else if (ctrl_valid) begin
            outs_next = CONST_V;
            cnt_next  = LAST_CNT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
